// File: rtl/gb_cart_bus_master.sv
// Game Boy cartridge bus initiator: turns single-byte requests into timed
// SETUP/STROBE/HOLD/RECOVER bus cycles with fully registered bus outputs.
module gb_cart_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic [15:0] Cart_a,
  inout  wire  [7:0]  Cart_d,
  output logic        Cart_nRD,
  output logic        Cart_nWR,
  output logic        Cart_nCS
);

  // STROBE_CYC >= 2 keeps the strobe visible through a two-flop synchroniser.
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 2 || STROBE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255 || RECOVER_CYC < 1 || RECOVER_CYC > 255) begin : g_bad_param
    $error("gb_cart_bus_master: phase length parameter out of range");
  end

  localparam logic [7:0] SetupLd   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] StrobeLd  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HoldLd    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RecoverLd = 8'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StStrobe  = 3'd2,
    StHold    = 3'd3,
    StRecover = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_write;
  logic [7:0]  r_wdata;
  logic [15:0] r_addr;
  logic        r_ready;
  logic        r_busy;
  logic        r_rsp_valid;
  logic [7:0]  r_rdata;
  logic        r_nrd;
  logic        r_nwr;
  logic        r_ncs;
  logic        r_d_oe;
  logic        w_in_ram;

  // External RAM / echo window that selects the cartridge RAM chip.
  assign w_in_ram = (req_addr >= 16'hA000) && (req_addr <= 16'hFDFF);

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_write     <= 1'b0;
      r_wdata     <= 8'h00;
      r_addr      <= 16'h0000;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
      r_nrd       <= 1'b1;
      r_nwr       <= 1'b1;
      r_ncs       <= 1'b1;
      r_d_oe      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_state <= StSetup;
            r_cnt   <= SetupLd;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_addr  <= req_addr;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_ncs   <= ~w_in_ram;
            r_d_oe  <= req_write;
          end
        end
        StSetup: begin
          if (r_cnt == 8'd0) begin
            r_state <= StStrobe;
            r_cnt   <= StrobeLd;
            r_nwr   <= ~r_write;
            r_nrd   <= r_write;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StStrobe: begin
          if (r_cnt == 8'd0) begin
            r_state <= StHold;
            r_cnt   <= HoldLd;
            r_nrd   <= 1'b1;
            r_nwr   <= 1'b1;
            if (!r_write) begin
              r_rdata <= Cart_d;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StHold: begin
          if (r_cnt == 8'd0) begin
            r_state     <= StRecover;
            r_cnt       <= RecoverLd;
            r_ncs       <= 1'b1;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StRecover: begin
          if (r_cnt == 8'd0) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_nrd   <= 1'b1;
          r_nwr   <= 1'b1;
          r_ncs   <= 1'b1;
          r_d_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign Cart_a    = r_addr;
  assign Cart_nRD  = r_nrd;
  assign Cart_nWR  = r_nwr;
  assign Cart_nCS  = r_ncs;
  assign Cart_d    = r_d_oe ? r_wdata : 8'hzz;

endmodule
